// File: rtl/fwu_sb.sv
`default_nettype none
// ============================================================================
// Module   : fwu_sb
// Summary  : rv32i forwarding and hazard unit with a scoreboard for
//            fixed-latency long operations (mul/div class). It drives the ALU
//            operand bypass selects, the decode stall, the long-op issue
//            handshake and the long-op writeback strobe.
// Options  : FWU_SB_STORE_FWD_EN adds the fwdWriteData store-data forward.
// Revision : 1.0 - initial release
// ============================================================================
module fwu_sb #(
    parameter int  RF_ADDR_WIDTH = 5,
    parameter int  NUM_PENDING   = 4,
    parameter int  MAX_LAT       = 8,
    localparam int LW            = $clog2(MAX_LAT + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [RF_ADDR_WIDTH-1:0] idRs1,
    input  logic [RF_ADDR_WIDTH-1:0] idRs2,
    input  logic [RF_ADDR_WIDTH-1:0] idRd,
    input  logic                     idRegWrite,
    input  logic [RF_ADDR_WIDTH-1:0] idexRs1,
    input  logic [RF_ADDR_WIDTH-1:0] idexRs2,
    input  logic [RF_ADDR_WIDTH-1:0] idexRd,
    input  logic                     idexMemRead,
    input  logic [RF_ADDR_WIDTH-1:0] exmemRd,
    input  logic [RF_ADDR_WIDTH-1:0] memwbRd,
    input  logic [RF_ADDR_WIDTH-1:0] exmemRs2,
    input  logic                     exmemRegWrite,
    input  logic                     memwbRegWrite,
    input  logic                     memwbMemToReg,
    input  logic                     exmemMemWrite,
    input  logic                     lopIssue,
    input  logic [RF_ADDR_WIDTH-1:0] lopRd,
    input  logic [LW-1:0]            lopLat,
    output logic                     lopReady,
    output logic [1:0]               fwdA,
    output logic [1:0]               fwdB,
    output logic                     stall,
    output logic                     lopWb,
    output logic [RF_ADDR_WIDTH-1:0] lopWbRd
`ifdef FWU_SB_STORE_FWD_EN
    ,
    output logic                     fwdWriteData
`endif
);

    localparam logic [1:0]    c_SEL_RF    = 2'b00;
    localparam logic [1:0]    c_SEL_MEMWB = 2'b01;
    localparam logic [1:0]    c_SEL_EXMEM = 2'b10;
    localparam logic [1:0]    c_SEL_LOP   = 2'b11;
    localparam logic [LW-1:0] c_CNT_ONE   = LW'(1);
    localparam logic [LW-1:0] c_CNT_TWO   = LW'(2);
    localparam logic [LW-1:0] c_CNT_THREE = LW'(3);
    localparam logic [LW-1:0] c_LAT_MAX   = LW'(MAX_LAT);

    // Scoreboard entries
    logic [NUM_PENDING-1:0]   r_valid;
    logic [RF_ADDR_WIDTH-1:0] r_rd  [NUM_PENDING];
    logic [LW-1:0]            r_cnt [NUM_PENDING];

    // Per-entry status vectors
    logic [NUM_PENDING-1:0]   w_retire;    // writing back this cycle (cnt == 1)
    logic [NUM_PENDING-1:0]   w_live;      // still pending after this cycle (cnt >= 2)
    logic [NUM_PENDING-1:0]   w_avail;     // can accept a new op at the next edge
    logic [NUM_PENDING-1:0]   w_issueWaw;  // pending write to the issuing op's rd
    logic [NUM_PENDING-1:0]   w_portHit;   // would share the writeback cycle with the new op
    logic [NUM_PENDING-1:0]   w_rawHit;    // decode source not yet bypassable
    logic [NUM_PENDING-1:0]   w_idWaw;     // decode destination still pending
    logic [NUM_PENDING-1:0]   w_allocSel;

    logic [LW-1:0]            w_effLat;
    logic [LW:0]              w_newWbCnt;
    logic [RF_ADDR_WIDTH-1:0] w_wbRd;
    logic                     w_doAlloc;
    logic                     w_loadUse;

    // Clamp the requested latency into [2, MAX_LAT]
    always_comb begin
        w_effLat = lopLat;
        if (lopLat < c_CNT_TWO) begin
            w_effLat = c_CNT_TWO;
        end else if (lopLat > c_LAT_MAX) begin
            w_effLat = c_LAT_MAX;
        end
    end

    // An existing entry whose count is one above the new op's latency reaches
    // cnt == 1 on the same cycle the new op would; widened to avoid wrap.
    assign w_newWbCnt = {1'b0, w_effLat} + (LW + 1)'(1);

    generate
        for (genvar i = 0; i < NUM_PENDING; i++) begin : g_entry
            assign w_retire[i]   = r_valid[i] && (r_cnt[i] == c_CNT_ONE);
            assign w_live[i]     = r_valid[i] && (r_cnt[i] >= c_CNT_TWO);
            assign w_avail[i]    = !r_valid[i] || w_retire[i];
            assign w_issueWaw[i] = w_live[i] && (r_rd[i] == lopRd);
            assign w_portHit[i]  = r_valid[i] && ({1'b0, r_cnt[i]} == w_newWbCnt);
            assign w_rawHit[i]   = r_valid[i] && (r_cnt[i] >= c_CNT_THREE) &&
                                   ((r_rd[i] == idRs1) || (r_rd[i] == idRs2));
            assign w_idWaw[i]    = w_live[i] && (r_rd[i] == idRd);
        end
    endgenerate

    // Writeback destination: at most one entry retires, so an OR of masked rd suffices
    always_comb begin
        w_wbRd = '0;
        for (int i = 0; i < NUM_PENDING; i++) begin
            if (w_retire[i]) begin
                w_wbRd = w_wbRd | r_rd[i];
            end
        end
    end

    // Pick the lowest-numbered slot that is free or freeing at the next edge
    always_comb begin
        w_allocSel = '0;
        for (int i = NUM_PENDING - 1; i >= 0; i--) begin
            if (w_avail[i]) begin
                w_allocSel    = '0;
                w_allocSel[i] = 1'b1;
            end
        end
    end

    assign lopReady  = (|w_avail) && !(|w_issueWaw) && !(|w_portHit);
    assign w_doAlloc = lopIssue && lopReady && (lopRd != '0);
    assign lopWb     = |w_retire;
    assign lopWbRd   = w_wbRd;

    assign w_loadUse = idexMemRead && (idexRd != '0) &&
                       ((idexRd == idRs1) || (idexRd == idRs2));

    assign stall = w_loadUse || (|w_rawHit) ||
                   (idRegWrite && (idRd != '0) && (|w_idWaw));

    // Bypass priority: youngest pipeline result first, long-op bus last
    function automatic logic [1:0] selFor(
        input logic [RF_ADDR_WIDTH-1:0] src,
        input logic                     exWr,
        input logic [RF_ADDR_WIDTH-1:0] exRd,
        input logic                     wbWr,
        input logic [RF_ADDR_WIDTH-1:0] wbRd,
        input logic                     lWb,
        input logic [RF_ADDR_WIDTH-1:0] lRd
    );
        logic [1:0] sel;
        sel = c_SEL_RF;
        if (src != '0) begin
            if (exWr && (exRd == src)) begin
                sel = c_SEL_EXMEM;
            end else if (wbWr && (wbRd == src)) begin
                sel = c_SEL_MEMWB;
            end else if (lWb && (lRd == src)) begin
                sel = c_SEL_LOP;
            end
        end
        return sel;
    endfunction

    // Operand selects for the EX-stage sources
    always_comb begin
        fwdA = selFor(idexRs1, exmemRegWrite, exmemRd, memwbRegWrite, memwbRd, lopWb, w_wbRd);
        fwdB = selFor(idexRs2, exmemRegWrite, exmemRd, memwbRegWrite, memwbRd, lopWb, w_wbRd);
    end

`ifdef FWU_SB_STORE_FWD_EN
    assign fwdWriteData = memwbMemToReg && exmemMemWrite &&
                          (memwbRd != '0) && (memwbRd == exmemRs2);
`else
    logic w_unusedStoreFwd;
    assign w_unusedStoreFwd = ^{memwbMemToReg, exmemMemWrite, exmemRs2};
`endif

    // Scoreboard update: allocate, retire or count down each entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_PENDING; i++) begin
                r_rd[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PENDING; i++) begin
                if (w_doAlloc && w_allocSel[i]) begin
                    r_valid[i] <= 1'b1;
                    r_rd[i]    <= lopRd;
                    r_cnt[i]   <= w_effLat;
                end else if (w_retire[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (r_valid[i]) begin
                    r_cnt[i]   <= r_cnt[i] - c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fwu_sb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fwu_sb
// Summary  : Scoreboard testbench for fwu_sb. A reference model tracks long
//            ops by absolute writeback cycle; expectations are queued per
//            cycle and compared by an independent monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwu_sb;

    localparam int AW = 5;
    localparam int NP = 4;
    localparam int ML = 8;
    localparam int LW = $clog2(ML + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] idRs1 = '0, idRs2 = '0, idRd = '0;
    logic          idRegWrite = 1'b0;
    logic [AW-1:0] idexRs1 = '0, idexRs2 = '0, idexRd = '0;
    logic          idexMemRead = 1'b0;
    logic [AW-1:0] exmemRd = '0, memwbRd = '0, exmemRs2 = '0;
    logic          exmemRegWrite = 1'b0, memwbRegWrite = 1'b0;
    logic          memwbMemToReg = 1'b0, exmemMemWrite = 1'b0;
    logic          lopIssue = 1'b0;
    logic [AW-1:0] lopRd = '0;
    logic [LW-1:0] lopLat = '0;
    logic          lopReady;
    logic [1:0]    fwdA, fwdB;
    logic          stall, lopWb;
    logic [AW-1:0] lopWbRd;
`ifdef FWU_SB_STORE_FWD_EN
    logic          fwdWriteData;
`endif

    fwu_sb #(.RF_ADDR_WIDTH(AW), .NUM_PENDING(NP), .MAX_LAT(ML)) dut (
        .clk(clk), .rst_n(rst_n),
        .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd), .idRegWrite(idRegWrite),
        .idexRs1(idexRs1), .idexRs2(idexRs2), .idexRd(idexRd), .idexMemRead(idexMemRead),
        .exmemRd(exmemRd), .memwbRd(memwbRd), .exmemRs2(exmemRs2),
        .exmemRegWrite(exmemRegWrite), .memwbRegWrite(memwbRegWrite),
        .memwbMemToReg(memwbMemToReg), .exmemMemWrite(exmemMemWrite),
        .lopIssue(lopIssue), .lopRd(lopRd), .lopLat(lopLat),
        .lopReady(lopReady), .fwdA(fwdA), .fwdB(fwdB), .stall(stall),
        .lopWb(lopWb), .lopWbRd(lopWbRd)
`ifdef FWU_SB_STORE_FWD_EN
        , .fwdWriteData(fwdWriteData)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ready;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          st;
        logic          wb;
        logic [AW-1:0] wbRd;
        logic          storeFwd;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rd;
        int            wbCyc;   // absolute cycle in which lopWb is high
    } op_t;

    exp_t expQ[$];
    op_t  pend[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [1:0] refSel(input logic [AW-1:0] src, input logic wb,
                                          input logic [AW-1:0] wbRd);
        if (src == 0) return 2'b00;
        if (exmemRegWrite && exmemRd == src) return 2'b10;
        if (memwbRegWrite && memwbRd == src) return 2'b01;
        if (wb && wbRd == src) return 2'b11;
        return 2'b00;
    endfunction

    task automatic beginCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic quietInputs();
        idRs1 = '0; idRs2 = '0; idRd = '0; idRegWrite = 1'b0;
        idexRs1 = '0; idexRs2 = '0; idexRd = '0; idexMemRead = 1'b0;
        exmemRd = '0; memwbRd = '0; exmemRs2 = '0;
        exmemRegWrite = 1'b0; memwbRegWrite = 1'b0;
        memwbMemToReg = 1'b0; exmemMemWrite = 1'b0;
        lopIssue = 1'b0; lopRd = '0; lopLat = '0;
    endtask

    task automatic randInputs();
        idRs1 = AW'($urandom_range(0, 7)); idRs2 = AW'($urandom_range(0, 7));
        idRd = AW'($urandom_range(0, 7)); idRegWrite = 1'($urandom_range(0, 1));
        idexRs1 = AW'($urandom_range(0, 7)); idexRs2 = AW'($urandom_range(0, 7));
        idexRd = AW'($urandom_range(0, 7)); idexMemRead = ($urandom_range(0, 3) == 0);
        exmemRd = AW'($urandom_range(0, 7)); memwbRd = AW'($urandom_range(0, 7));
        exmemRs2 = AW'($urandom_range(0, 7));
        exmemRegWrite = 1'($urandom_range(0, 1)); memwbRegWrite = 1'($urandom_range(0, 1));
        memwbMemToReg = 1'($urandom_range(0, 1)); exmemMemWrite = 1'($urandom_range(0, 1));
        lopIssue = 1'($urandom_range(0, 1));
        lopRd = AW'($urandom_range(0, 7));
        lopLat = LW'($urandom_range(0, (1 << LW) - 1));
    endtask

    // Reference model: derive this cycle's outputs from pending writeback cycles
    task automatic finishCycle();
        exp_t e;
        int   L;
        int   newWb;
        bit   retiring, waw, port, raw, idWaw;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].wbCyc < cyc) pend.delete(i);
        e.wb = 1'b0; e.wbRd = '0;
        retiring = 0; waw = 0; port = 0; raw = 0; idWaw = 0;
        L = int'(lopLat);
        if (L < 2) L = 2;
        if (L > ML) L = ML;
        newWb = cyc + L;
        foreach (pend[i]) begin
            int left;
            left = pend[i].wbCyc - cyc;
            if (left == 0) begin
                e.wb = 1'b1; e.wbRd = pend[i].rd; retiring = 1;
            end
            if (left > 0 && pend[i].rd == lopRd) waw = 1;
            if (pend[i].wbCyc == newWb) port = 1;
            if (left >= 2 && (pend[i].rd == idRs1 || pend[i].rd == idRs2)) raw = 1;
            if (left > 0 && pend[i].rd == idRd) idWaw = 1;
        end
        e.ready = (pend.size() < NP || retiring) && !waw && !port;
        e.st = (idexMemRead && idexRd != 0 && (idexRd == idRs1 || idexRd == idRs2)) ||
               raw || (idRegWrite && idRd != 0 && idWaw);
        e.fa = refSel(idexRs1, e.wb, e.wbRd);
        e.fb = refSel(idexRs2, e.wb, e.wbRd);
        e.storeFwd = memwbMemToReg && exmemMemWrite && memwbRd != 0 && memwbRd == exmemRs2;
        expQ.push_back(e);
        if (rst_n && lopIssue && e.ready && lopRd != 0) begin
            op_t o;
            o.rd = lopRd;
            o.wbCyc = newWb;
            pend.push_back(o);
        end
    endtask

    task automatic doReset(input int n);
        for (int k = 0; k < n; k++) begin
            beginCycle(); rst_n = 1'b0; quietInputs(); pend.delete(); finishCycle();
        end
        beginCycle(); rst_n = 1'b1; quietInputs(); finishCycle();
    endtask

    task automatic issue(input int rd, input int lat);
        beginCycle(); quietInputs();
        lopIssue = 1'b1; lopRd = AW'(rd); lopLat = LW'(lat);
        finishCycle();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            beginCycle(); quietInputs(); finishCycle();
        end
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    initial begin
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                exp_t e;
                e = expQ.pop_front();
                chk("lopReady", 32'(lopReady), 32'(e.ready));
                chk("fwdA", 32'(fwdA), 32'(e.fa));
                chk("fwdB", 32'(fwdB), 32'(e.fb));
                chk("stall", 32'(stall), 32'(e.st));
                chk("lopWb", 32'(lopWb), 32'(e.wb));
                chk("lopWbRd", 32'(lopWbRd), 32'(e.wbRd));
`ifdef FWU_SB_STORE_FWD_EN
                chk("fwdWriteData", 32'(fwdWriteData), 32'(e.storeFwd));
`endif
            end
        end
    end

    initial begin
        quietInputs();
        doReset(2);

        // Long-op RAW: consumer of x5 waits in ID, then bypasses from the long-op bus
        issue(5, 4);
        for (int k = 0; k < 5; k++) begin
            beginCycle(); quietInputs(); idRs1 = 5; idexRs1 = 5; finishCycle();
        end

        // Forwarding priority and x0
        beginCycle(); quietInputs();
        exmemRd = 7; memwbRd = 7; idexRs2 = 7; exmemRegWrite = 1; memwbRegWrite = 1;
        finishCycle();
        beginCycle(); quietInputs();
        exmemRd = 7; memwbRd = 7; idexRs2 = 0; exmemRegWrite = 1; memwbRegWrite = 1;
        finishCycle();

        // Fill the scoreboard, then keep requesting until a retiring slot frees up
        for (int r = 1; r <= 4; r++) issue(r, 8);
        for (int k = 0; k < 8; k++) issue(6, 8);
        idle(12);

        // WAW and writeback port conflict
        issue(3, 6);
        beginCycle(); quietInputs();
        lopIssue = 1; lopRd = 3; lopLat = 4; idRegWrite = 1; idRd = 3;
        finishCycle();
        issue(8, 4);
        idle(8);

        // Load-use and store-data forwarding
        beginCycle(); quietInputs();
        idexMemRead = 1; idexRd = 9; idRs2 = 9;
        finishCycle();
        beginCycle(); quietInputs();
        memwbMemToReg = 1; memwbRegWrite = 1; memwbRd = 9; exmemMemWrite = 1; exmemRs2 = 9;
        finishCycle();

        // Reset with two ops in flight: nothing may write back afterwards
        issue(10, 5);
        issue(11, 7);
        idle(1);
        doReset(2);
        idle(10);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset(1);
            end else begin
                beginCycle(); randInputs(); finishCycle();
            end
        end

        repeat (3) @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
